ads131_spi_responder: RTL and testbench

//  SPI slave model of the ADS131A0x command interface (CPOL=0, CPHA=1, 32-bit frames, MSB first).
//  - Answers the SPI master exactly as the ADC does: each frame returns the response to the previous command.
//  - Drives DRDY and honours the ADC reset pin.
//  - Sits on the FPGA side for loopback/board bring-up and serves as the bus-functional partner in SPI_Master benches.
//

---
 rtl/ads131_pkg.sv | 63 ++++++
 rtl/spi_pin_sync.sv | 45 ++++
 rtl/ads131_spi_responder.sv | 169 ++++++++++++++++
 tb/tb_ads131_spi_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ads131_pkg.sv
// Shared constants, state encoding and command decoder for the ADS131A0x SPI responder.
package ads131_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [15:0] OP_NULL    = 16'h0000;
  localparam logic [15:0] OP_UNLOCK  = 16'h0655;
  localparam logic [15:0] OP_LOCK    = 16'h0555;
  localparam logic [15:0] OP_WAKEUP  = 16'h0033;
  localparam logic [15:0] OP_STANDBY = 16'h0022;
  localparam logic [2:0]  OP_WREG    = 3'b010;
  localparam logic [2:0]  RSP_WREG   = 3'b001;
  localparam logic [4:0]  REG_ADC_ENA = 5'h0F;
  localparam logic [31:0] READY_WORD = 32'hFF04_0000;
  localparam logic [15:0] STAT_1     = 16'h2200;

  typedef enum logic [1:0] {
    DEV_BOOT     = 2'd0,
    DEV_LOCKED   = 2'd1,
    DEV_UNLOCKED = 2'd2
  } dev_state_t;

  typedef struct packed {
    logic [31:0] resp;
    dev_state_t  state;
    logic        awake;
    logic        ena_we;
  } decode_t;

  // Response and side effects of one completed command word.
  function automatic decode_t decode_cmd(input logic [15:0] cmd, input dev_state_t st,
                                         input logic awake);
    decode_t d;
    d.resp   = '0;
    d.state  = st;
    d.awake  = awake;
    d.ena_we = 1'b0;
    if (cmd == OP_NULL) begin
      d.resp = (st == DEV_LOCKED) ? READY_WORD : {STAT_1, 16'h0000};
    end else if (cmd == OP_UNLOCK) begin
      d.resp  = {OP_UNLOCK, 16'h0000};
      d.state = DEV_UNLOCKED;
    end else if (cmd == OP_LOCK) begin
      d.resp  = {OP_LOCK, 16'h0000};
      d.state = DEV_LOCKED;
    end else if (cmd == OP_WAKEUP) begin
      if (st == DEV_UNLOCKED) begin
        d.resp  = {OP_WAKEUP, 16'h0000};
        d.awake = 1'b1;
      end
    end else if (cmd == OP_STANDBY) begin
      if (st == DEV_UNLOCKED) begin
        d.resp  = {OP_STANDBY, 16'h0000};
        d.awake = 1'b0;
      end
    end else if (cmd[15:13] == OP_WREG && st == DEV_UNLOCKED) begin
      d.resp   = {RSP_WREG, cmd[12:0], 16'h0000};
      d.ena_we = (cmd[12:8] == REG_ADC_ENA);
    end
    return d;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins and flags sclk/cs edges in the system_clock domain.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic system_clock,
  input  logic reset,
  input  logic spi_sclk,
  input  logic spi_cs,
  input  logic spi_mosi,
  input  logic spi_reset_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic cs_lvl,
  output logic mosi_lvl,
  output logic reset_n_lvl
);

  // Pin order {reset_n, mosi, cs, sclk}; reset_n resets low so the device stays held until the pin is seen high.
  localparam logic [3:0] RST_VAL = 4'b0010;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [1:0]                  prev_q;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL[1:0];
    end else begin
      sync_q[0] <= {spi_reset_n, spi_mosi, spi_cs, spi_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1][1:0];
    end
  end

  assign sclk_rise   =  sync_q[SYNC_STAGES-1][0] & ~prev_q[0];
  assign sclk_fall   = ~sync_q[SYNC_STAGES-1][0] &  prev_q[0];
  assign cs_rise     =  sync_q[SYNC_STAGES-1][1] & ~prev_q[1];
  assign cs_fall     = ~sync_q[SYNC_STAGES-1][1] &  prev_q[1];
  assign cs_lvl      =  sync_q[SYNC_STAGES-1][1];
  assign mosi_lvl    =  sync_q[SYNC_STAGES-1][2];
  assign reset_n_lvl =  sync_q[SYNC_STAGES-1][3];

endmodule

// File: rtl/ads131_spi_responder.sv
// ADS131A0x command-interface SPI slave model: boot timer, 32-bit frame shifter, command FSM, DRDY timer.
module ads131_spi_responder
  import ads131_pkg::*;
#(
  parameter int BOOT_CYCLES = 1000,
  parameter int DRDY_PERIOD = 12500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  input  logic        spi_reset_n,
  output logic        spi_miso,
  output logic        spi_drdy,
  output logic [1:0]  dev_state,
  output logic        awake,
  output logic [7:0]  adc_ena,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  output logic [7:0]  frame_err_cnt
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int DRDY_W = $clog2(DRDY_PERIOD + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [DRDY_W-1:0] DRDY_LAST = DRDY_W'(DRDY_PERIOD - 1);
  localparam logic [DRDY_W-1:0] HALF_LAST = DRDY_W'(DRDY_PERIOD / 2 - 1);
  localparam logic [5:0] FRAME_LEN = 6'(FRAME_BITS);
  localparam logic [5:0] CMD_LEN   = 6'd16;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl, mosi_lvl, reset_n_lvl;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .system_clock (system_clock),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_reset_n  (spi_reset_n),
    .sclk_rise    (sclk_rise),
    .sclk_fall    (sclk_fall),
    .cs_rise      (cs_rise),
    .cs_fall      (cs_fall),
    .cs_lvl       (cs_lvl),
    .mosi_lvl     (mosi_lvl),
    .reset_n_lvl  (reset_n_lvl)
  );

  logic              dev_rst;
  dev_state_t        state_q, state_d;
  logic              awake_d, ena_we;
  logic [31:0]       resp_q, resp_d, tx_q;
  logic [15:0]       rx_q;
  logic [5:0]        bitcnt;
  logic              frame_act, frame_done, frame_abort, boot_done;
  logic [BOOT_W-1:0] boot_cnt;
  logic [DRDY_W-1:0] drdy_cnt;
  decode_t           dec;

  assign dev_rst     = ~reset_n_lvl;
  assign dev_state   = state_q;
  assign boot_done   = (state_q == DEV_BOOT) && (boot_cnt == BOOT_LAST);
  assign frame_done  = cs_rise && frame_act && (bitcnt == FRAME_LEN) && (state_q != DEV_BOOT);
  assign frame_abort = cs_rise && frame_act && (bitcnt != '0) && (bitcnt < FRAME_LEN) &&
                       (state_q != DEV_BOOT);
  assign dec         = decode_cmd(rx_q, state_q, awake);

  always_comb begin
    state_d = state_q;
    awake_d = awake;
    resp_d  = resp_q;
    ena_we  = 1'b0;
    if (boot_done) begin
      state_d = DEV_LOCKED;
      resp_d  = READY_WORD;
    end else if (frame_done) begin
      state_d = dec.state;
      awake_d = dec.awake;
      resp_d  = dec.resp;
      ena_we  = dec.ena_we;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q  <= DEV_BOOT;
      awake    <= 1'b0;
      resp_q   <= '0;
      adc_ena  <= '0;
      boot_cnt <= '0;
    end else if (dev_rst) begin
      state_q  <= DEV_BOOT;
      awake    <= 1'b0;
      resp_q   <= '0;
      adc_ena  <= '0;
      boot_cnt <= '0;
    end else begin
      state_q <= state_d;
      awake   <= awake_d;
      resp_q  <= resp_d;
      if (ena_we) adc_ena <= rx_q[7:0];
      if (state_q == DEV_BOOT && !boot_done) boot_cnt <= boot_cnt + BOOT_W'(1);
    end
  end

  // Only the first 16 MOSI bits (the command word) are kept; the rest of the frame is clocked past.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bitcnt    <= '0;
      frame_act <= 1'b0;
      spi_miso  <= 1'b0;
      cmd_word  <= '0;
      cmd_valid <= 1'b0;
    end else if (dev_rst) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bitcnt    <= '0;
      frame_act <= 1'b0;
      spi_miso  <= 1'b0;
      cmd_word  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= frame_done;
      if (frame_done) cmd_word <= rx_q;
      if (cs_fall) begin
        tx_q      <= resp_q;
        bitcnt    <= '0;
        frame_act <= 1'b1;
        spi_miso  <= 1'b0;
      end else if (cs_rise) begin
        frame_act <= 1'b0;
        spi_miso  <= 1'b0;
      end else if (cs_lvl) begin
        spi_miso <= 1'b0;
      end else if (frame_act && sclk_rise) begin
        spi_miso <= (bitcnt < FRAME_LEN) ? tx_q[~bitcnt[4:0]] : 1'b0;
      end else if (frame_act && sclk_fall && bitcnt < FRAME_LEN) begin
        if (bitcnt < CMD_LEN) rx_q <= {rx_q[14:0], mosi_lvl};
        bitcnt <= bitcnt + 6'd1;
      end
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) frame_err_cnt <= '0;
    else if (!dev_rst && frame_abort && frame_err_cnt != 8'hFF)
      frame_err_cnt <= frame_err_cnt + 8'd1;
  end

  // DRDY falls on each counter wrap and rises after half a period or when the master opens a frame.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      drdy_cnt <= '0;
      spi_drdy <= 1'b1;
    end else if (dev_rst || !awake) begin
      drdy_cnt <= '0;
      spi_drdy <= 1'b1;
    end else begin
      drdy_cnt <= (drdy_cnt == DRDY_LAST) ? '0 : drdy_cnt + DRDY_W'(1);
      if (drdy_cnt == DRDY_LAST) spi_drdy <= 1'b0;
      else if (cs_fall || (!spi_drdy && drdy_cnt == HALF_LAST)) spi_drdy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ads131_spi_responder.sv
// Directed bench for ads131_spi_responder with a frame-level command model and a per-cycle compare.
module tb_ads131_spi_responder;

  localparam int BOOT = 1000;
  localparam int DP   = 12500;

  logic        clk = 1'b0, rst = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, rstn_pin = 1'b1;
  logic        miso, drdy, awake, cmd_valid;
  logic [1:0]  dev_state;
  logic [7:0]  adc_ena, frame_err_cnt;
  logic [15:0] cmd_word;

  ads131_spi_responder #(.BOOT_CYCLES(BOOT), .DRDY_PERIOD(DP), .SYNC_STAGES(2)) dut (
    .system_clock  (clk),
    .reset         (rst),
    .spi_sclk      (sclk),
    .spi_cs        (cs_n),
    .spi_mosi      (mosi),
    .spi_reset_n   (rstn_pin),
    .spi_miso      (miso),
    .spi_drdy      (drdy),
    .dev_state     (dev_state),
    .awake         (awake),
    .adc_ena       (adc_ena),
    .cmd_word      (cmd_word),
    .cmd_valid     (cmd_valid),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Device model: state 0=BOOT 1=LOCKED 2=UNLOCKED.
  logic [1:0]  m_state = 2'd0;
  logic        m_awake = 1'b0;
  logic [7:0]  m_adc = 8'h00, m_err = 8'h00;
  logic [31:0] m_resp = 32'h0;
  logic [15:0] m_cmd = 16'h0;
  int          m_vld = 0, vld_seen = 0;
  logic        chk_en = 1'b0;

  task automatic model_frame(input logic [15:0] cmd, input int nbits);
    logic [31:0] r;
    if (m_state == 2'd0) return;
    if (nbits == 32) begin
      m_cmd = cmd;
      m_vld++;
      r = 32'h0;
      case (cmd)
        16'h0000: r = (m_state == 2'd1) ? 32'hFF04_0000 : 32'h2200_0000;
        16'h0655: begin r = 32'h0655_0000; m_state = 2'd2; end
        16'h0555: begin r = 32'h0555_0000; m_state = 2'd1; end
        16'h0033: if (m_state == 2'd2) begin r = 32'h0033_0000; m_awake = 1'b1; end
        16'h0022: if (m_state == 2'd2) begin r = 32'h0022_0000; m_awake = 1'b0; end
        default:
          if (cmd[15:13] == 3'b010 && m_state == 2'd2) begin
            r = {3'b001, cmd[12:0], 16'h0000};
            if (cmd[12:8] == 5'h0F) m_adc = cmd[7:0];
          end
      endcase
      m_resp = r;
    end else if (nbits > 0 && m_err != 8'hFF) begin
      m_err = m_err + 8'd1;
    end
  endtask

  always @(negedge clk) if (cmd_valid) vld_seen <= vld_seen + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_state", 32'(dev_state), 32'(m_state));
      chk("cyc_awake", 32'(awake), 32'(m_awake));
      chk("cyc_adc_ena", 32'(adc_ena), 32'(m_adc));
      chk("cyc_err_cnt", 32'(frame_err_cnt), 32'(m_err));
      chk("cyc_cmd_word", 32'(cmd_word), 32'(m_cmd));
      if (cs_n) chk("cyc_miso_idle", 32'(miso), 32'h0);
      if (!m_awake) chk("cyc_drdy_idle", 32'(drdy), 32'h1);
    end
  end

  // CPOL=0/CPHA=1 master: drive on rising SCLK, sample on falling; SCLK period = 16 system clocks.
  task automatic xfer(input logic [15:0] cmd, input int nbits, output logic [31:0] rx);
    logic [31:0] w;
    w  = {cmd, 16'h0000};
    rx = '0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = w[31-i];
      repeat (8) @(negedge clk);
      rx[31-i] = miso;
      sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input string nm, input logic [15:0] cmd, input int nbits,
                       output logic [31:0] rx);
    logic [31:0] mask, exp;
    logic        old_en;
    mask   = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
    exp    = m_resp & mask;
    old_en = chk_en;
    chk_en = 1'b0;
    xfer(cmd, nbits, rx);
    chk(nm, rx, exp);
    repeat (6) @(negedge clk);
    model_frame(cmd, nbits);
    chk_en = old_en;
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int t1, w;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_drdy", 32'(drdy), 32'h1);
    chk("rst_state", 32'(dev_state), 32'h0);
    chk("rst_awake", 32'(awake), 32'h0);
    chk("rst_adc_ena", 32'(adc_ena), 32'h0);
    chk("rst_cmd_word", 32'(cmd_word), 32'h0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_err_cnt", 32'(frame_err_cnt), 32'h0);
    rst = 1'b0;
    t1 = cyc;

    // Test 1: a NULL clocked while booting reads zeros, then READY once booted.
    frame("t1_null_boot", 16'h0000, 32, r);
    chk("t1_null_boot_lit", r, 32'h0);
    while (cyc < t1 + BOOT - 20) @(negedge clk);
    chk("t1_still_boot", 32'(dev_state), 32'h0);
    while (cyc < t1 + BOOT + 20) @(negedge clk);
    chk("t1_locked", 32'(dev_state), 32'h1);
    m_state = 2'd1;
    m_resp  = 32'hFF04_0000;
    chk_en  = 1'b1;
    frame("t1_null_ready", 16'h0000, 32, r);
    chk("t1_ready_lit", r, 32'hFF04_0000);

    // Test 2: unlock, wake, write ADC_ENA, relock.
    frame("t2_unlock", 16'h0655, 32, r);  chk("t2_unlock_lit", r, 32'hFF04_0000);
    frame("t2_wakeup", 16'h0033, 32, r);  chk("t2_wakeup_lit", r, 32'h0655_0000);
    frame("t2_wreg", 16'h4F0F, 32, r);    chk("t2_wreg_lit", r, 32'h0033_0000);
    frame("t2_lock", 16'h0555, 32, r);    chk("t2_lock_lit", r, 32'h2F0F_0000);
    frame("t2_null", 16'h0000, 32, r);    chk("t2_null_lit", r, 32'h0555_0000);
    chk("t2_adc_ena", 32'(adc_ena), 32'h0F);
    chk("t2_awake", 32'(awake), 32'h1);
    chk("t2_state", 32'(dev_state), 32'h1);

    // Test 5: DRDY cadence with no frames, then a CS fall during the low phase.
    w = 0;
    while (drdy !== 1'b1 && w < DP) begin @(negedge clk); w++; end
    w = 0;
    while (drdy !== 1'b0 && w < DP + 100) begin @(negedge clk); w++; end
    chk("t5_fall1", 32'(drdy), 32'h0);
    t1 = cyc;
    w = 0;
    while (drdy !== 1'b1 && w < DP) begin @(negedge clk); w++; end
    chk("t5_rise", 32'(drdy), 32'h1);
    chk("t5_low_width", 32'(cyc - t1), 32'(DP / 2));
    w = 0;
    while (drdy !== 1'b0 && w < DP) begin @(negedge clk); w++; end
    chk("t5_fall2", 32'(drdy), 32'h0);
    chk("t5_period", 32'(cyc - t1), 32'(DP));
    repeat (100) @(negedge clk);
    chk("t5_low_mid", 32'(drdy), 32'h0);
    cs_n = 1'b0;
    w = 0;
    while (drdy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    chk("t5_cs_release", 32'(drdy), 32'h1);
    chk("t5_cs_latency", 32'(w <= 3), 32'h1);
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);

    // Test 4: aborted frame counts an error and leaves the response alone.
    frame("t4_abort", 16'h0000, 17, r);
    chk("t4_err_lit", 32'(frame_err_cnt), 32'h1);
    frame("t4_next", 16'h0000, 32, r);
    chk("t4_next_lit", r, 32'hFF04_0000);

    // Test 6: device reset pin pulsed mid-frame.
    chk_en = 1'b0;
    fork
      xfer(16'h0000, 32, r);
      begin
        repeat (172) @(negedge clk);
        rstn_pin = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_state", 32'(dev_state), 32'h0);
        chk("t6_awake", 32'(awake), 32'h0);
        chk("t6_miso", 32'(miso), 32'h0);
        chk("t6_drdy", 32'(drdy), 32'h1);
        chk("t6_adc_ena", 32'(adc_ena), 32'h0);
        chk("t6_err_kept", 32'(frame_err_cnt), 32'h1);
        repeat (34) @(negedge clk);
        rstn_pin = 1'b1;
      end
    join
    chk("t6_rx_cut", r, 32'hFF00_0000);
    m_state = 2'd0; m_awake = 1'b0; m_adc = 8'h00; m_resp = 32'h0; m_cmd = 16'h0;
    repeat (900) @(negedge clk);
    chk("t6_relocked", 32'(dev_state), 32'h1);
    m_state = 2'd1;
    m_resp  = 32'hFF04_0000;
    chk_en  = 1'b1;
    frame("t6_ready", 16'h0000, 32, r);
    chk("t6_ready_lit", r, 32'hFF04_0000);

    // Test 3: WAKEUP is refused while LOCKED.
    frame("t3_wakeup", 16'h0033, 32, r);  chk("t3_wakeup_lit", r, 32'hFF04_0000);
    frame("t3_null", 16'h0000, 32, r);    chk("t3_null_lit", r, 32'h0);
    chk("t3_awake", 32'(awake), 32'h0);
    w = 0;
    repeat (DP + 200) begin
      @(negedge clk);
      if (drdy !== 1'b1) w++;
    end
    chk("t3_drdy_high", 32'(w), 32'h0);
    chk("cmd_valid_pulses", 32'(vld_seen), 32'(m_vld));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
